fractal_sync_lock_requester: RTL and testbench

- Initiator-side endpoint for one port of the fractal sync queue register file.
- Accepts acquire and release commands from a local master (core or CU wrapper).
- Converts them into single-cycle lock/free pulses with id and element on the RF port, waits for the RF grant, and reports completion or errors upstream.
- One instance per RF port; it can sit behind either the horizontal or the vertical half of a 2D RF.

---
 rtl/fractal_sync_pkg.sv | 11 +
 rtl/fractal_sync_timeout_cnt.sv | 20 ++
 rtl/fractal_sync_lock_requester.sv | 111 +++++++++++
 tb/tb_fractal_sync_lock_requester.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared state and error-code enums for the fractal sync lock requester
package fractal_sync_pkg;
  typedef enum logic [2:0] {IDLE, LOCK, WAIT, HELD, FREE, ERR} fs_req_state_e;
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ID       = 3'd1,
    ERR_OVF      = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_SPURIOUS = 3'd4
  } fs_req_err_e;
endpackage

// File: rtl/fractal_sync_timeout_cnt.sv
// fractal_sync_timeout_cnt: counts WAIT cycles and flags the last one before a timeout
module fractal_sync_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_WIDTH = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] cnt;
  // cycle counter, restarted whenever the requester is not waiting
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else if (clr_i) cnt <= '0;
    else if (en_i) cnt <= cnt + 1'b1;
  assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && cnt == LAST;
endmodule

// File: rtl/fractal_sync_lock_requester.sv
// fractal_sync_lock_requester: turns acquire/release commands into RF lock/free pulses and tracks the grant
module fractal_sync_lock_requester
  import fractal_sync_pkg::*;
#(
  parameter int  ID_WIDTH       = 1,
  parameter type element_t      = logic,
  parameter int  TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                acquire_valid_i,
  output logic                acquire_ready_o,
  input  logic [ID_WIDTH-1:0] acquire_id_i,
  input  element_t            acquire_element_i,
  input  logic                release_valid_i,
  output logic                release_ready_o,
  output logic                done_valid_o,
  output element_t            done_element_o,
  output logic                err_valid_o,
  output logic [2:0]          err_code_o,
  input  logic                err_clr_i,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                lock_o,
  output logic                free_o,
  output element_t            element_o,
  input  logic                grant_i,
  input  element_t            element_i,
  input  logic                id_err_i,
  input  logic                overflow_error_i
);
  fs_req_state_e       state;
  fs_req_err_e         err;
  logic [ID_WIDTH-1:0] id_q;
  element_t            el_q;
  logic                expired;
  fractal_sync_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state != WAIT),
    .en_i     (state == WAIT),
    .expired_o(expired)
  );
  // request FSM: captures the lock, sequences lock/wait/held/free and records errors
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state          <= IDLE;
      err            <= ERR_NONE;
      id_q           <= '0;
      el_q           <= '0;
      done_valid_o   <= 1'b0;
      done_element_o <= '0;
    end else begin
      done_valid_o <= 1'b0;
      case (state)
        IDLE:
          if (grant_i) begin
            state <= ERR;
            err   <= ERR_SPURIOUS;
          end else if (acquire_valid_i) begin
            state <= LOCK;
            id_q  <= acquire_id_i;
            el_q  <= acquire_element_i;
          end
        LOCK:
          if (id_err_i) begin
            state <= ERR;
            err   <= ERR_ID;
          end else if (overflow_error_i) begin
            state <= ERR;
            err   <= ERR_OVF;
          end else if (grant_i) begin
            state          <= HELD;
            done_valid_o   <= 1'b1;
            done_element_o <= element_i;
          end else state <= WAIT;
        WAIT:
          if (grant_i) begin
            state          <= HELD;
            done_valid_o   <= 1'b1;
            done_element_o <= element_i;
          end else if (expired) begin
            state <= ERR;
            err   <= ERR_TIMEOUT;
          end
        HELD:
          if (grant_i) begin
            state <= ERR;
            err   <= ERR_SPURIOUS;
          end else if (release_valid_i) state <= FREE;
        FREE:
          if (overflow_error_i) begin
            state <= ERR;
            err   <= ERR_OVF;
          end else state <= IDLE;
        ERR:
          if (err_clr_i) begin
            state <= IDLE;
            err   <= ERR_NONE;
          end
        default: state <= IDLE;
      endcase
    end
  assign acquire_ready_o = state == IDLE;
  assign release_ready_o = state == HELD;
  assign lock_o          = state == LOCK;
  assign free_o          = state == FREE;
  assign err_valid_o     = state == ERR;
  assign err_code_o      = err;
  assign id_o            = id_q;
  assign element_o       = el_q;
endmodule

// File: tb/tb_fractal_sync_lock_requester.sv
// tb_fractal_sync_lock_requester: per-cycle vector table plus an asynchronous reset sequence
module tb_fractal_sync_lock_requester;
  typedef logic [3:0] el_t;
  typedef struct {
    logic av; el_t aid; el_t ael; logic rv; logic clr; logic g; el_t ein; logic ie; logic ov;
    logic ar; logic rr; logic dv; el_t de; logic ev; logic [2:0] ec; el_t id; logic lk; logic fr; el_t eo;
  } vec_t;
  logic clk = 0, rst = 1;
  logic acquire_valid = 0, release_valid = 0, err_clr = 0, grant = 0, id_err = 0, overflow = 0;
  el_t acquire_id = 0, acquire_element = 0, element_in = 0;
  logic acquire_ready, release_ready, done_valid, err_valid, lock, free;
  el_t done_element, id, element_out;
  logic [2:0] err_code;
  int compared = 0, mismatched = 0;
  vec_t q[$];
  fractal_sync_lock_requester #(.ID_WIDTH(4), .element_t(el_t), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .acquire_valid_i(acquire_valid), .acquire_ready_o(acquire_ready),
    .acquire_id_i(acquire_id), .acquire_element_i(acquire_element),
    .release_valid_i(release_valid), .release_ready_o(release_ready),
    .done_valid_o(done_valid), .done_element_o(done_element),
    .err_valid_o(err_valid), .err_code_o(err_code), .err_clr_i(err_clr),
    .id_o(id), .lock_o(lock), .free_o(free), .element_o(element_out),
    .grant_i(grant), .element_i(element_in), .id_err_i(id_err), .overflow_error_i(overflow)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input logic av, input el_t aid, input el_t ael, input logic rv,
      input logic clr, input logic g, input el_t ein, input logic ie, input logic ov,
      input logic ar, input logic rr, input logic dv, input el_t de, input logic ev,
      input logic [2:0] ec, input el_t id, input logic lk, input logic fr, input el_t eo);
    vec_t r;
    r.av = av; r.aid = aid; r.ael = ael; r.rv = rv; r.clr = clr; r.g = g; r.ein = ein; r.ie = ie; r.ov = ov;
    r.ar = ar; r.rr = rr; r.dv = dv; r.de = de; r.ev = ev; r.ec = ec; r.id = id; r.lk = lk; r.fr = fr; r.eo = eo;
    return r;
  endfunction
  task automatic chk(input string name, input vec_t e);
    logic [20:0] got, exp;
    got = {acquire_ready, release_ready, done_valid, done_element, err_valid, err_code, id, lock, free, element_out};
    exp = {e.ar, e.rr, e.dv, e.de, e.ev, e.ec, e.id, e.lk, e.fr, e.eo};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got ar,rr,dv,de,ev,ec,id,lk,fr,eo=%b,%b,%b,%h,%b,%0d,%h,%b,%b,%h expected %b,%b,%b,%h,%b,%0d,%h,%b,%b,%h",
        name, got[20], got[19], got[18], got[17:14], got[13], got[12:10], got[9:6], got[5], got[4], got[3:0],
        exp[20], exp[19], exp[18], exp[17:14], exp[13], exp[12:10], exp[9:6], exp[5], exp[4], exp[3:0]);
    end
  endtask
  initial begin
    // fall-through grant, then release
    q.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0));
    q.push_back(v(1,3,1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0));
    q.push_back(v(0,0,0,0,0,1,1,0,0, 0,0,0,0,0,0,3,1,0,1));
    q.push_back(v(0,0,0,1,0,0,0,0,0, 0,1,1,1,0,0,3,0,0,1));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0,3,0,1,1));
    // delayed grant with release held through WAIT
    q.push_back(v(1,5,6,0,0,0,0,0,0, 1,0,0,1,0,0,3,0,0,1));
    q.push_back(v(0,0,0,1,0,0,0,0,0, 0,0,0,1,0,0,5,1,0,6));
    for (int i = 0; i < 4; i++) q.push_back(v(0,0,0,1,0,0,0,0,0, 0,0,0,1,0,0,5,0,0,6));
    q.push_back(v(0,0,0,1,0,1,9,0,0, 0,0,0,1,0,0,5,0,0,6));
    q.push_back(v(0,0,0,1,0,0,0,0,0, 0,1,1,9,0,0,5,0,0,6));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,9,0,0,5,0,1,6));
    // id error beats overflow and grant; acquire in ERR stalls
    q.push_back(v(1,2,4,0,0,0,0,0,0, 1,0,0,9,0,0,5,0,0,6));
    q.push_back(v(0,0,0,0,0,1,9,1,1, 0,0,0,9,0,0,2,1,0,4));
    q.push_back(v(1,15,15,0,0,0,0,0,0, 0,0,0,9,1,1,2,0,0,4));
    q.push_back(v(0,0,0,0,1,0,0,0,0, 0,0,0,9,1,1,2,0,0,4));
    // overflow in LOCK beats grant
    q.push_back(v(1,7,2,0,0,0,0,0,0, 1,0,0,9,0,0,2,0,0,4));
    q.push_back(v(0,0,0,0,0,1,9,0,1, 0,0,0,9,0,0,7,1,0,2));
    q.push_back(v(0,0,0,0,1,0,0,0,0, 0,0,0,9,1,2,7,0,0,2));
    // timeout after 8 WAIT cycles
    q.push_back(v(1,1,3,0,0,0,0,0,0, 1,0,0,9,0,0,7,0,0,2));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,9,0,0,1,1,0,3));
    for (int i = 0; i < 8; i++) q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,9,0,0,1,0,0,3));
    q.push_back(v(0,0,0,0,1,0,0,0,0, 0,0,0,9,1,3,1,0,0,3));
    // grant on WAIT cycle 7, then overflow on FREE
    q.push_back(v(1,4,5,0,0,0,0,0,0, 1,0,0,9,0,0,1,0,0,3));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,9,0,0,4,1,0,5));
    for (int i = 0; i < 6; i++) q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,9,0,0,4,0,0,5));
    q.push_back(v(0,0,0,0,0,1,10,0,0, 0,0,0,9,0,0,4,0,0,5));
    q.push_back(v(0,0,0,1,0,0,0,0,0, 0,1,1,10,0,0,4,0,0,5));
    q.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,10,0,0,4,0,1,5));
    q.push_back(v(0,0,0,0,1,0,0,0,0, 0,0,0,10,1,2,4,0,0,5));
    // spurious grant in IDLE and in HELD
    q.push_back(v(0,0,0,0,0,1,10,0,0, 1,0,0,10,0,0,4,0,0,5));
    q.push_back(v(1,15,15,0,0,0,0,0,0, 0,0,0,10,1,4,4,0,0,5));
    q.push_back(v(0,0,0,0,1,0,0,0,0, 0,0,0,10,1,4,4,0,0,5));
    q.push_back(v(1,6,7,0,0,0,0,0,0, 1,0,0,10,0,0,4,0,0,5));
    q.push_back(v(0,0,0,0,0,1,11,0,0, 0,0,0,10,0,0,6,1,0,7));
    q.push_back(v(0,0,0,0,0,1,11,0,0, 0,1,1,11,0,0,6,0,0,7));
    q.push_back(v(0,0,0,0,1,0,0,0,0, 0,0,0,11,1,4,6,0,0,7));
    // grant in the same cycle as the timeout wins; stay in HELD
    q.push_back(v(1,8,1,0,0,0,0,0,0, 1,0,0,11,0,0,6,0,0,7));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,11,0,0,8,1,0,1));
    for (int i = 0; i < 7; i++) q.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,11,0,0,8,0,0,1));
    q.push_back(v(0,0,0,0,0,1,12,0,0, 0,0,0,11,0,0,8,0,0,1));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,1,1,12,0,0,8,0,0,1));
    q.push_back(v(0,0,0,0,0,0,0,0,0, 0,1,0,12,0,0,8,0,0,1));
    repeat (2) @(negedge clk);
    rst = 0;
    foreach (q[i]) begin
      @(negedge clk);
      acquire_valid = q[i].av; acquire_id = q[i].aid; acquire_element = q[i].ael;
      release_valid = q[i].rv; err_clr = q[i].clr; grant = q[i].g; element_in = q[i].ein;
      id_err = q[i].ie; overflow = q[i].ov;
      chk($sformatf("row%0d", i), q[i]);
    end
    // asynchronous reset while HELD, away from any clock edge
    #2 rst = 1;
    #1 chk("async_reset", v(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), v(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
